// File: rtl/md_iter_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract; one bit per cycle.
// Stall_EX holds the pipeline from the start cycle until the single-cycle done pulse.
module md_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             Stall_EX,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    // Operand/iteration datapath; captured on accept, no reset needed
    logic               div_q;      // 1: divide, 0: multiply
    logic               negq_q;     // negate product / quotient
    logic               negr_q;     // negate remainder (dividend sign)
    logic               bzero_q;    // divisor was zero
    logic [WIDTH-1:0]   araw_q;     // raw dividend for the divide-by-zero result
    logic [WIDTH-1:0]   opb_q;      // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;      // mult: {partial, multiplier}; div: {remainder, quotient}

    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_shift, div_diff, div_rem;
    logic [2*WIDTH-1:0] div_acc;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    assign accept = (state_q == IDLE) && start && !cancel;

    // One radix-2 iteration of both algorithms plus the sign-corrected final result
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_rem   = div_diff[WIDTH] ? div_shift : div_diff;
        div_acc   = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        step_acc  = div_q ? div_acc : mul_acc;
        prod      = neg_2w(mul_acc, negq_q);
        if (!div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (bzero_q) begin
            res_hi = araw_q;
            res_lo = '1;
        end else begin
            res_hi = neg_w(div_acc[2*WIDTH-1:WIDTH], negr_q);
            res_lo = neg_w(div_acc[WIDTH-1:0], negq_q);
        end
    end

    // Control state, iteration counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand capture on accept, then one iteration per BUSY cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            div_q   <= op[1];
            negq_q  <= op[0] && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            negr_q  <= op[0] && src_a[WIDTH-1];
            bzero_q <= (src_b == '0);
            araw_q  <= src_a;
            opb_q   <= op[1] ? mag(src_b, op[0]) : mag(src_a, op[0]);
            acc_q   <= {{WIDTH{1'b0}}, (op[1] ? mag(src_a, op[0]) : mag(src_b, op[0]))};
        end else if (state_q == BUSY) begin
            acc_q   <= step_acc;
        end
    end

    // Next-state logic; cancel wins over completion, DONE never re-samples start
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        Stall_EX = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    Stall_EX = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                Stall_EX = 1'b1;
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 6'(WIDTH-1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            DONE: begin
                Stall_EX = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Scoreboard bench for md_iter_unit: stimulus pushes expected HI/LO and done cycle,
// a negedge monitor pops and compares whenever done is presented.
module tb_md_iter_unit;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        Stall_EX, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    md_iter_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .Stall_EX(Stall_EX), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one op, hold start through DONE (scrambling operands mid-BUSY), then drop it
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int t;
        bit seen;
        @(posedge clk); #1;
        op = o; src_a = a; src_b = b; start = 1'b1;
        t = cyc;
        q.push_back('{eh, el, t + 33});
        #1 chk("stall_on_start", 64'(Stall_EX), 64'd1);
        seen = 0;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(negedge clk);
            if (i == 3) begin
                src_a = ~a; src_b = b ^ 32'h5a5a_5a5a; op = ~o;
            end
            if (done) seen = 1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("stall_after_done", 64'(Stall_EX), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic count_quiet(input string name, input int n);
        int nd;
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk(name, 64'(nd), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = MULTU; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(Stall_EX), 64'd0);

        // start together with cancel is not accepted
        start = 1'b1; cancel = 1'b1; src_a = 32'd9; src_b = 32'd9;
        #1 chk("stall_start_cancel", 64'(Stall_EX), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        #1 chk("no_accept_on_cancel", 64'(Stall_EX), 64'd0);

        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op(MULT,  32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0014);
        do_op(MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780);
        do_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_op(DIVU,  32'd1000,      32'd7,         32'd6,         32'd142);
        do_op(DIV,   32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);

        // cancel at T+10 of a DIVU: back to IDLE, no done, previous result kept
        @(posedge clk); #1;
        op = DIVU; src_a = 32'd50; src_b = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        #1 chk("stall_before_cancel", 64'(Stall_EX), 64'd1);
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        #1;
        chk("cancel_stall", 64'(Stall_EX), 64'd0);
        chk("cancel_hi_kept", 64'(hi), 64'h64);
        chk("cancel_lo_kept", 64'(lo), 64'hFFFF_FFFF);
        count_quiet("cancel_no_done", 40);

        // reset at T+5: operation discarded, results cleared
        @(posedge clk); #1;
        op = DIVU; src_a = 32'd50; src_b = 32'd3; start = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_stall", 64'(Stall_EX), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        count_quiet("midrst_no_done", 40);

        // back-to-back with a single idle cycle between ops
        do_op(MULTU, 32'd2, 32'd2, 32'd0, 32'd4);
        do_op(MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Iterative multiply/divide unit in the EX stage; executes MULT, MULTU, DIV and DIVU.
- Drives the Stall_EX and done inputs of the hazard-detection/control block.
- That block stalls F/D/E/M/W while Stall_EX && !done.
- Produces the 64-bit HI:LO result consumed by the HI/LO register write in M.

Parameters:
WIDTH, 32, operand width; also the iteration count.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  MD instruction present in EX (level, held while stalled)
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
src_a  input  WIDTH  rs operand (multiplicand / dividend)
src_b  input  WIDTH  rt operand (multiplier / divisor)
cancel  input  1  abort current operation (driven by Exception_Clear)
Stall_EX  output  1  unit requests pipeline hold
done  output  1  result valid this cycle; releases the stall
hi  output  WIDTH  product[63:32] or remainder
lo  output  WIDTH  product[31:0] or quotient

Behaviour:
- States: IDLE, BUSY, DONE. Iteration counter cnt is 0..WIDTH-1, 6 bits.
- Reset (rst=1 at clk edge):
  - state=IDLE, cnt=0, done=0.
  - hi/lo registers=0.
  - Stall_EX=0, except that the start term below remains combinational.
- IDLE:
  - start=1 && cancel=0 → capture op, capture sign flags, capture |src_a| and |src_b| (signed ops only; unsigned ops use raw values); cnt=0; go to BUSY.
  - Otherwise remain in IDLE.
- BUSY: one radix-2 step per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, remainder WIDTH+1 bits.
  - At cnt=WIDTH-1: apply sign correction, load hi/lo, go to DONE. Otherwise cnt++.
- DONE:
  - done=1 for exactly one cycle; hi/lo hold final values.
  - Always returns to IDLE next cycle, even if start is still high. The pipeline advances out of EX on this cycle, so start is not re-sampled here.
- Latency: start sampled in IDLE at cycle T → BUSY during T+1..T+WIDTH → DONE at T+WIDTH+1.
- Stall_EX = (state==IDLE && start && !cancel) || state==BUSY || state==DONE. It is combinational so the start cycle stalls immediately.
  - Effective stall = T..T+WIDTH.
  - In DONE, Stall_EX=1 and done=1, so the pipeline is not held.
- hi/lo persist after DONE until the next completion or reset. They are registered outputs.
- Sign rules:
  - MULT: product negated iff sign_a XOR sign_b.
  - DIV: quotient negated iff sign_a XOR sign_b; remainder takes the sign of the dividend.
- Divide by zero (any DIV/DIVU): lo=all ones, hi=src_a as captured (raw, not magnitude). Full latency is still taken.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. This arises naturally from the magnitude arithmetic.
- cancel in any state: next state=IDLE, cnt=0, done=0, hi/lo unchanged. cancel has priority over completion at cnt=WIDTH-1.
- rst has priority over cancel and start. Reset mid-operation discards the operation.
- Ops change mid-BUSY: src_a/src_b/op are ignored after capture.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF → Stall_EX high from start cycle; done pulses exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- MULT src_a=0xFFFFFFFD (-3), src_b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; one-cycle done; Stall_EX drops the cycle after done.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU src_a=100, src_b=0 → after 33 cycles, lo=0xFFFFFFFF, hi=0x00000064.
- cancel asserted at cycle T+10 of a DIVU → next cycle IDLE, Stall_EX=0, no done pulse, hi/lo keep previous result. rst at T+5 → same, plus hi=lo=0.
- Back-to-back: start held through DONE, then dropped one cycle, then raised for a new MULTU 3*5 → exactly one done for the first op; second done 33 cycles after re-start; lo=15, hi=0.
